// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_sequencer
//  Description : Four-state instruction sequencer (IDLE/DECODE/EXECUTE/
//                WRITEBACK). Accepts one instruction word per handshake,
//                latches its opcode and register fields, drives datapath
//                mux selects, and pulses the execute and memory-write
//                strobes. It also counts retired instructions.
//                Optional feature macro: ILLEGAL_OP_TRAP_EN. When it is
//                defined, opcodes with the MSB set that are not one of the
//                four memory ops raise IllegalOp instead of executing.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int INSTR_W = 32,
    parameter int OP_W    = 5,
    parameter int REG_W   = 13,
    parameter int CNT_W   = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               InstrValid,
    input  logic [INSTR_W-1:0] Instruction,
    output logic               InstrReady,
    output logic [OP_W-1:0]    ALUOpCode,
    output logic [REG_W-1:0]   RegA,
    output logic [REG_W-1:0]   RegB,
    output logic               RegBMemMux,
    output logic               RegARegCMux,
    output logic               RegCMemOutMux,
    output logic               MemWrite,
    output logic               ExecValid,
    output logic               IllegalOp,
    output logic [CNT_W-1:0]   InstrCount
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_DECODE    = 2'd1;
    localparam logic [1:0] S_EXECUTE   = 2'd2;
    localparam logic [1:0] S_WRITEBACK = 2'd3;

    // Field positions, counted down from the instruction MSB
    localparam int OP_MSB = INSTR_W - 1;
    localparam int RA_MSB = INSTR_W - OP_W - 1;
    localparam int RB_MSB = INSTR_W - OP_W - REG_W - 1;

    // Opcode bits between the MSB and the low one-hot nibble (empty when OP_W is 5)
    localparam logic [OP_W-1:0] MID_MASK = OP_W'((1 << (OP_W - 5)) - 1);

    logic [1:0]       state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [REG_W-1:0] rega_q, rega_d;
    logic [REG_W-1:0] regb_q, regb_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic accept;
    logic busy;
    logic nibble_one_hot;
    logic mid_zero;
    logic is_mem_op;
    logic is_mem_add_sub;
    logic is_mem_display;
    logic is_mem_clear;
    logic illegal_class;
    logic retire;

    // Low instruction bits below RegB carry no meaning; fold them away
    logic unused_instr_bits;
    assign unused_instr_bits = ^Instruction;

    assign accept = (state_q == S_IDLE) && InstrValid;
    assign busy   = (state_q != S_IDLE);

    // Memory-op classification works on the latched opcode
    assign nibble_one_hot = (op_q[3:0] == 4'b0001) || (op_q[3:0] == 4'b0010) ||
                            (op_q[3:0] == 4'b0100) || (op_q[3:0] == 4'b1000);
    assign mid_zero       = (((op_q >> 4) & MID_MASK) == '0);
    assign is_mem_op      = op_q[OP_W-1] && mid_zero && nibble_one_hot;
    assign is_mem_add_sub = is_mem_op && (op_q[0] || op_q[1]);
    assign is_mem_display = is_mem_op && op_q[2];
    assign is_mem_clear   = is_mem_op && op_q[3];

`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal_class = op_q[OP_W-1] && !is_mem_op;
`else
    assign illegal_class = 1'b0;
`endif

    // An instruction retires only when it actually executes
    assign retire = (state_q == S_EXECUTE) && !illegal_class;

    // State register; reset drops any in-flight instruction
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing: memory ops take the extra writeback cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (InstrValid) state_d = S_DECODE;
            S_DECODE:    state_d = S_EXECUTE;
            S_EXECUTE:   state_d = is_mem_op ? S_WRITEBACK : S_IDLE;
            S_WRITEBACK: state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Strobes and mux selects decoded from the current state
    always_comb begin
        InstrReady    = (state_q == S_IDLE);
        RegBMemMux    = busy && is_mem_add_sub;
        RegARegCMux   = busy && is_mem_display;
        RegCMemOutMux = busy && is_mem_clear;
        ExecValid     = (state_q == S_EXECUTE) && !illegal_class;
        IllegalOp     = (state_q == S_EXECUTE) && illegal_class;
        MemWrite      = (state_q == S_WRITEBACK);
    end

    // Field capture on accept and retired-instruction counting
    always_comb begin
        op_d    = op_q;
        rega_d  = rega_q;
        regb_d  = regb_q;
        count_d = count_q;
        if (accept) begin
            op_d   = Instruction[OP_MSB -: OP_W];
            rega_d = Instruction[RA_MSB -: REG_W];
            regb_d = Instruction[RB_MSB -: REG_W];
        end
        if (retire) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            op_q    <= '0;
            rega_q  <= '0;
            regb_q  <= '0;
            count_q <= '0;
        end else begin
            op_q    <= op_d;
            rega_q  <= rega_d;
            regb_q  <= regb_d;
            count_q <= count_d;
        end
    end

    assign ALUOpCode  = op_q;
    assign RegA       = rega_q;
    assign RegB       = regb_q;
    assign InstrCount = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_sequencer
//  Description : Self-checking bench for instr_sequencer (CNT_W = 2 so the
//                counter wrap is reachable). Expected execute and memory-
//                write events are queued at each handshake and compared
//                when the DUT produces them.
//                Honours ILLEGAL_OP_TRAP_EN in the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    localparam int INSTR_W = 32;
    localparam int OP_W    = 5;
    localparam int REG_W   = 13;
    localparam int CNT_W   = 2;

`ifdef ILLEGAL_OP_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic               Clk = 1'b0;
    logic               Reset;
    logic               InstrValid;
    logic [INSTR_W-1:0] Instruction;
    logic               InstrReady;
    logic [OP_W-1:0]    ALUOpCode;
    logic [REG_W-1:0]   RegA;
    logic [REG_W-1:0]   RegB;
    logic               RegBMemMux;
    logic               RegARegCMux;
    logic               RegCMemOutMux;
    logic               MemWrite;
    logic               ExecValid;
    logic               IllegalOp;
    logic [CNT_W-1:0]   InstrCount;

    instr_sequencer #(
        .INSTR_W (INSTR_W),
        .OP_W    (OP_W),
        .REG_W   (REG_W),
        .CNT_W   (CNT_W)
    ) u_dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .InstrValid    (InstrValid),
        .Instruction   (Instruction),
        .InstrReady    (InstrReady),
        .ALUOpCode     (ALUOpCode),
        .RegA          (RegA),
        .RegB          (RegB),
        .RegBMemMux    (RegBMemMux),
        .RegARegCMux   (RegARegCMux),
        .RegCMemOutMux (RegCMemOutMux),
        .MemWrite      (MemWrite),
        .ExecValid     (ExecValid),
        .IllegalOp     (IllegalOp),
        .InstrCount    (InstrCount)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        int         cyc;
        logic [4:0] op;
        logic [12:0] ra;
        logic [12:0] rb;
        logic       exec;
        logic       illegal;
        logic       mux_a;
        logic       mux_b;
        logic       mux_c;
        logic [1:0] cnt_before;
        logic [1:0] cnt_after;
    } exp_t;

    exp_t       exq[$];
    int         mwq[$];
    logic [1:0] exp_count   = 2'd0;
    int         mw_seen     = 0;
    bit         cnt_pending = 1'b0;
    logic [1:0] cnt_after   = 2'd0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference classification straight from the opcode encoding rules
    task automatic push_expect(input logic [31:0] instr, input int n);
        exp_t e;
        logic [4:0] op;
        logic is_mem;
        op          = instr[31:27];
        is_mem      = op[4] && (op[3:0] == 4'd1 || op[3:0] == 4'd2 ||
                                op[3:0] == 4'd4 || op[3:0] == 4'd8);
        e.cyc       = n + 1;
        e.op        = op;
        e.ra        = instr[26:14];
        e.rb        = instr[13:1];
        e.illegal   = TRAP_EN && op[4] && !is_mem;
        e.exec      = !e.illegal;
        e.mux_b     = is_mem && (op[3:0] == 4'd1 || op[3:0] == 4'd2);
        e.mux_a     = is_mem && (op[3:0] == 4'd4);
        e.mux_c     = is_mem && (op[3:0] == 4'd8);
        e.cnt_before = exp_count;
        if (e.exec) exp_count = exp_count + 2'd1;
        e.cnt_after = exp_count;
        exq.push_back(e);
        if (is_mem) mwq.push_back(n + 2);
    endtask

    // Monitor: compare DUT events against the scoreboard at the falling edge
    always @(negedge Clk) begin : mon
        exp_t e;
        if (cnt_pending) begin
            check_value("count_after_exec", InstrCount, cnt_after);
            cnt_pending = 1'b0;
        end
        if (ExecValid || IllegalOp) begin
            check_value("exec_expected", exq.size() != 0, 1);
            if (exq.size() != 0) begin
                e = exq.pop_front();
                check_value("exec_cycle", cyc, e.cyc);
                check_value("exec_valid", ExecValid, e.exec);
                check_value("illegal_op", IllegalOp, e.illegal);
                check_value("opcode", ALUOpCode, e.op);
                check_value("rega", RegA, e.ra);
                check_value("regb", RegB, e.rb);
                check_value("mux_regb_mem", RegBMemMux, e.mux_b);
                check_value("mux_rega_regc", RegARegCMux, e.mux_a);
                check_value("mux_regc_memout", RegCMemOutMux, e.mux_c);
                check_value("count_at_exec", InstrCount, e.cnt_before);
                cnt_after   = e.cnt_after;
                cnt_pending = 1'b1;
            end
        end
        if (MemWrite) begin
            mw_seen++;
            check_value("memwrite_expected", mwq.size() != 0, 1);
            if (mwq.size() != 0) check_value("memwrite_cycle", cyc, mwq.pop_front());
        end
    end

    task automatic send(input logic [31:0] instr, input bit hold, output int n);
        int waited;
        waited = 0;
        @(negedge Clk);
        InstrValid  = 1'b1;
        Instruction = instr;
        while (!InstrReady && waited < 20) begin
            @(negedge Clk);
            waited++;
        end
        if (waited >= 20) check_value("accept_timeout", InstrReady, 1);
        n = cyc + 1;
        push_expect(instr, n);
        @(posedge Clk);
        #1;
        if (!hold) InstrValid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int i;
        i = 0;
        while ((exq.size() != 0 || mwq.size() != 0 || !InstrReady) && i < 30) begin
            @(negedge Clk);
            i++;
        end
        @(negedge Clk);
        check_value(tag, exq.size() + mwq.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_ready"}, InstrReady, 1);
        check_value({tag, "_opcode"}, ALUOpCode, 0);
        check_value({tag, "_rega"}, RegA, 0);
        check_value({tag, "_regb"}, RegB, 0);
        check_value({tag, "_muxes"}, {RegBMemMux, RegARegCMux, RegCMemOutMux}, 0);
        check_value({tag, "_strobes"}, {MemWrite, ExecValid, IllegalOp}, 0);
        check_value({tag, "_count"}, InstrCount, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int n, n1, n2, mw0;
        logic [1:0] cnt0;
        logic [31:0] instr;
        int wrap_seq[5];
        wrap_seq = '{1, 2, 3, 0, 1};

        Reset       = 1'b1;
        InstrValid  = 1'b0;
        Instruction = '0;
        repeat (3) @(negedge Clk);
        check_reset_outputs("reset");
        Reset = 1'b0;
        @(negedge Clk);

        // Plain ALU op
        mw0 = mw_seen;
        send(32'h0800_4002, 1'b0, n);
        wait_drain("alu_drain");
        check_value("alu_count", InstrCount, 1);
        check_value("alu_hold_opcode", ALUOpCode, 5'b00001);
        check_value("alu_hold_fields", {RegA, RegB}, {13'd1, 13'd1});
        check_value("alu_no_memwrite", mw_seen - mw0, 0);

        // MemAdd with cycle-by-cycle mux and strobe checks
        instr = {5'b10001, 13'h0A5, 13'h15A, 1'b1};
        send(instr, 1'b0, n);
        @(negedge Clk);
        check_value("memadd_decode", {InstrReady, RegBMemMux, ExecValid, MemWrite}, 4'b0100);
        @(negedge Clk);
        check_value("memadd_exec", {InstrReady, RegBMemMux, ExecValid, MemWrite}, 4'b0110);
        @(negedge Clk);
        check_value("memadd_wb", {InstrReady, RegBMemMux, ExecValid, MemWrite}, 4'b0101);
        @(negedge Clk);
        check_value("memadd_idle", {InstrReady, RegBMemMux, ExecValid, MemWrite}, 4'b1000);
        wait_drain("memadd_drain");

        // Back-to-back MemClear then MemDisplay with valid held high
        mw0 = mw_seen;
        send({5'b11000, 13'h1FFF, 13'h0001, 1'b0}, 1'b1, n1);
        send({5'b10100, 13'h0002, 13'h1000, 1'b0}, 1'b0, n2);
        check_value("b2b_accept_gap", n2 - n1, 4);
        wait_drain("b2b_drain");
        check_value("b2b_memwrites", mw_seen - mw0, 2);

        // Reset during DECODE of a MemSub drops it
        mw0 = mw_seen;
        send({5'b10010, 13'h0033, 13'h0044, 1'b0}, 1'b0, n);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        exq.delete();
        mwq.delete();
        exp_count = 2'd0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        check_value("midreset_count", InstrCount, 0);
        check_value("midreset_no_memwrite", mw_seen - mw0, 0);

        // Counter wrap with CNT_W = 2
        for (int i = 0; i < 5; i++) begin
            send({2'b00, 3'(i + 1), 13'(i * 3), 13'(i + 7), 1'b0}, 1'b0, n);
            wait_drain("wrap_drain");
            check_value("wrap_count", InstrCount, wrap_seq[i]);
        end

        // Opcode 10011: trapped or executed as an ALU op
        mw0  = mw_seen;
        cnt0 = exp_count;
        send({5'b10011, 13'h0ABC, 13'h0123, 1'b0}, 1'b0, n);
        wait_drain("op10011_drain");
        check_value("op10011_count", InstrCount, TRAP_EN ? cnt0 : cnt0 + 2'd1);
        check_value("op10011_no_memwrite", mw_seen - mw0, 0);

        // Random words, mostly back-to-back
        for (int i = 0; i < 8; i++) begin
            send($urandom, (i != 7), n);
        end
        wait_drain("random_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter INSTR_W, default 32, meaning instruction word width.
REQ-002 SHALL have parameter OP_W, default 5, meaning opcode field width; legal range 5 to INSTR_W-2.
REQ-003 SHALL have parameter REG_W, default 13, meaning register-field width; OP_W+2*REG_W <= INSTR_W.
REQ-004 SHALL have parameter CNT_W, default 16, meaning retired-instruction counter width.
REQ-005 Clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 InstrValid  input  1  upstream has an instruction on Instruction.
REQ-008 Instruction  input  INSTR_W  instruction word.
REQ-009 InstrReady  output  1  block can accept an instruction this cycle.
REQ-010 ALUOpCode  output  OP_W  latched opcode field.
REQ-011 RegA  output  REG_W  latched first operand field.
REQ-012 RegB  output  REG_W  latched second operand field.
REQ-013 RegBMemMux, RegARegCMux, RegCMemOutMux  output  1 each  datapath mux selects.
REQ-014 MemWrite  output  1  memory write strobe.
REQ-015 ExecValid  output  1  one-cycle execute strobe to the ALU.
REQ-016 IllegalOp  output  1  one-cycle illegal-opcode flag (see Configuration).
REQ-017 InstrCount  output  CNT_W  number of instructions retired.

Function
REQ-018 SHALL decode fields: ALUOpCode = Instruction[INSTR_W-1 -: OP_W]; RegA = next REG_W bits below; RegB = next REG_W bits below RegA; remaining LSBs are ignored.
REQ-019 SHALL classify memory ops as opcode MSB=1, bits [OP_W-2:4] zero, bits [3:0] one-hot: 0001 MemAdd, 0010 MemSub, 0100 MemDisplay, 1000 MemClear; every other opcode is an ALU op.
REQ-020 SHALL implement FSM states IDLE, DECODE, EXECUTE, WRITEBACK.
REQ-021 IDLE: InstrReady=1; on InstrValid=1, latch Instruction and go to DECODE; InstrValid=0 stays in IDLE.
REQ-022 DECODE: InstrReady=0; drive the latched fields and the mux selects; next state EXECUTE.
REQ-023 Mux selects: MemAdd/MemSub -> RegBMemMux=1; MemDisplay -> RegARegCMux=1; MemClear -> RegCMemOutMux=1; all others 0; held constant from DECODE until return to IDLE, then cleared.
REQ-024 EXECUTE: ExecValid=1 for exactly one cycle; InstrCount increments with wrap from 2^CNT_W-1 to 0; next state WRITEBACK for memory ops, otherwise IDLE.
REQ-025 WRITEBACK: MemWrite=1 for exactly one cycle; next state IDLE; MemWrite SHALL never assert outside WRITEBACK.
REQ-026 Latency: for a handshake at edge N, ExecValid is high in cycle N+2 and MemWrite in cycle N+3; throughput is one ALU op per 3 cycles and one memory op per 4 cycles.
REQ-027 Instruction and InstrValid SHALL be ignored outside IDLE; upstream holds its word until InstrReady=1.
REQ-028 ALUOpCode, RegA and RegB SHALL hold their last value in IDLE until the next accept.

Reset
REQ-029 Reset SHALL force IDLE immediately, with InstrReady=1 and every other output 0, including InstrCount.
REQ-030 Reset mid-instruction SHALL drop that instruction: no ExecValid, no MemWrite, no count increment.

Configuration
REQ-031 With ILLEGAL_OP_TRAP_EN defined: an opcode with MSB=1 that is not one of the four memory ops SHALL set IllegalOp=1 in the EXECUTE cycle instead of ExecValid, with no MemWrite and no count increment, and return to IDLE.
REQ-032 With ILLEGAL_OP_TRAP_EN undefined: IllegalOp SHALL be tied 0, and such opcodes SHALL execute as ALU ops.

Verification
REQ-033 Reset, then accept ALU op 0x0800_4002 -> ALUOpCode=00001, RegA=1, RegB=1; ExecValid high at N+2; no MemWrite; InstrCount=1.
REQ-034 Accept MemAdd (opcode 10001) -> RegBMemMux=1 from N+1 to N+3; ExecValid at N+2; MemWrite at N+3 only; InstrReady=1 at N+4.
REQ-035 Hold InstrValid=1 continuously with MemClear then MemDisplay -> second accept at N+4; RegCMemOutMux then RegARegCMux; exactly two MemWrite pulses.
REQ-036 Assert Reset during DECODE of a MemSub -> all outputs 0 at once; no ExecValid or MemWrite; InstrCount=0.
REQ-037 With CNT_W=2, retire 5 ALU ops -> InstrCount sequence 1,2,3,0,1.
REQ-038 Opcode 10011 -> with ILLEGAL_OP_TRAP_EN defined: IllegalOp pulse at N+2, no ExecValid, count unchanged; with it undefined: ExecValid at N+2 and no MemWrite.
